line_scheduler: RTL and testbench

Sequences and shares the single line-drawing datapath between two requesters: a draw client (port A) and an erase client (port B). Each accepted request is a line segment plus a colour. The scheduler launches the drawer, stamps every pixel the drawer emits with the granted requester's colour, and forwards it to the framebuffer write port. A watchdog aborts lines that never complete. It sits between the animation/control logic and the pixel-write path of the VGA framebuffer.

---
 rtl/line_scheduler_if.sv | 50 +++++
 rtl/line_scheduler.sv | 126 ++++++++++++
 tb/tb_line_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_scheduler_if.sv
//------------------------------------------------------------------------------
// line_scheduler_if : request ports A/B, drawer handshake and pixel-write bus
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface line_scheduler_if #(
  parameter int W  = 11,
  parameter int CW = 1
);
  logic          a_req;
  logic [W-1:0]  a_x0, a_y0, a_x1, a_y1;
  logic [CW-1:0] a_color;
  logic          a_ack;

  logic          b_req;
  logic [W-1:0]  b_x0, b_y0, b_x1, b_y1;
  logic [CW-1:0] b_color;
  logic          b_ack;

  logic          drw_start;
  logic [W-1:0]  drw_x0, drw_y0, drw_x1, drw_y1;
  logic [W-1:0]  drw_x, drw_y;
  logic          drw_pvalid;
  logic          drw_done;

  logic          pix_we;
  logic [W-1:0]  pix_x, pix_y;
  logic [CW-1:0] pix_color;

  // Environment side: requesters, drawer model and framebuffer
  modport master (
    output a_req, a_x0, a_y0, a_x1, a_y1, a_color,
    output b_req, b_x0, b_y0, b_x1, b_y1, b_color,
    output drw_x, drw_y, drw_pvalid, drw_done,
    input  a_ack, b_ack, drw_start, drw_x0, drw_y0, drw_x1, drw_y1,
    input  pix_we, pix_x, pix_y, pix_color
  );

  // Scheduler side
  modport slave (
    input  a_req, a_x0, a_y0, a_x1, a_y1, a_color,
    input  b_req, b_x0, b_y0, b_x1, b_y1, b_color,
    input  drw_x, drw_y, drw_pvalid, drw_done,
    output a_ack, b_ack, drw_start, drw_x0, drw_y0, drw_x1, drw_y1,
    output pix_we, pix_x, pix_y, pix_color
  );
endinterface

`default_nettype wire

// File: rtl/line_scheduler.sv
//------------------------------------------------------------------------------
// line_scheduler : round-robin sharing of one line drawer between two clients
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module line_scheduler #(
  parameter int W       = 11,
  parameter int CW      = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  line_scheduler_if.slave   bus,
  output logic              busy,
  output logic              err_timeout,
  output logic [15:0]       line_count
);

  localparam int            TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WD_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    DRAW   = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t        state;
  logic          last_grant_b;
  logic          grant_b;
  logic [CW-1:0] color;
  logic [TW-1:0] wd_cnt;
  logic          pick_b;

  // Both pending: serve whoever was not granted last; otherwise serve the one pending
  assign pick_b = bus.b_req && (!bus.a_req || !last_grant_b);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_grant_b  <= 1'b1;
      grant_b       <= 1'b0;
      color         <= '0;
      wd_cnt        <= '0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
      line_count    <= '0;
      bus.drw_start <= 1'b0;
      bus.drw_x0    <= '0;
      bus.drw_y0    <= '0;
      bus.drw_x1    <= '0;
      bus.drw_y1    <= '0;
      bus.pix_we    <= 1'b0;
      bus.pix_x     <= '0;
      bus.pix_y     <= '0;
      bus.pix_color <= '0;
      bus.a_ack     <= 1'b0;
      bus.b_ack     <= 1'b0;
    end else begin
      bus.drw_start <= 1'b0;
      bus.pix_we    <= 1'b0;
      bus.a_ack     <= 1'b0;
      bus.b_ack     <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.a_req || bus.b_req) begin
            grant_b       <= pick_b;
            last_grant_b  <= pick_b;
            bus.drw_x0    <= pick_b ? bus.b_x0    : bus.a_x0;
            bus.drw_y0    <= pick_b ? bus.b_y0    : bus.a_y0;
            bus.drw_x1    <= pick_b ? bus.b_x1    : bus.a_x1;
            bus.drw_y1    <= pick_b ? bus.b_y1    : bus.a_y1;
            color         <= pick_b ? bus.b_color : bus.a_color;
            bus.drw_start <= 1'b1;
            busy          <= 1'b1;
            state         <= LAUNCH;
          end
        end

        LAUNCH: begin
          wd_cnt <= '0;
          state  <= DRAW;
        end

        DRAW: begin
          if (bus.drw_pvalid) begin
            bus.pix_we    <= 1'b1;
            bus.pix_x     <= bus.drw_x;
            bus.pix_y     <= bus.drw_y;
            bus.pix_color <= color;
          end
          // A genuine completion wins over a watchdog expiry in the same cycle
          if (bus.drw_pvalid && bus.drw_done) begin
            line_count <= line_count + 16'd1;
            bus.a_ack  <= !grant_b;
            bus.b_ack  <= grant_b;
            state      <= ACK;
          end else if (wd_cnt == WD_MAX) begin
            err_timeout <= 1'b1;
            bus.a_ack   <= !grant_b;
            bus.b_ack   <= grant_b;
            state       <= ACK;
          end else begin
            wd_cnt <= wd_cnt + TW'(1);
          end
        end

        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_scheduler.sv
//------------------------------------------------------------------------------
// tb_line_scheduler : directed self-checking bench with a behavioural drawer
//------------------------------------------------------------------------------
`default_nettype none

module tb_line_scheduler;
  localparam int W  = 11;
  localparam int CW = 1;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        busy;
  logic        err_timeout;
  logic [15:0] line_count;

  int checks   = 0;
  int failures = 0;

  line_scheduler_if #(.W(W), .CW(CW)) bus ();

  line_scheduler #(.W(W), .CW(CW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .busy        (busy),
    .err_timeout (err_timeout),
    .line_count  (line_count)
  );

  always #5 clk = ~clk;

  int px[$];
  int py[$];
  int pc[$];
  int ack_q[$];
  int a_acks = 0;
  int b_acks = 0;

  always @(negedge clk) begin
    if (bus.pix_we === 1'b1) begin
      px.push_back(int'(bus.pix_x));
      py.push_back(int'(bus.pix_y));
      pc.push_back(int'(bus.pix_color));
    end
    if (bus.a_ack === 1'b1) begin a_acks++; ack_q.push_back(0); end
    if (bus.b_ack === 1'b1) begin b_acks++; ack_q.push_back(1); end
  end

  // Drawer model: horizontal lines x0..x1 on row y0, one pixel per cycle
  logic hang = 1'b0;
  int   m_x0, m_n, m_y;
  initial begin
    bus.drw_pvalid = 1'b0;
    bus.drw_done   = 1'b0;
    bus.drw_x      = '0;
    bus.drw_y      = '0;
    forever begin
      @(negedge clk);
      if (reset_n && bus.drw_start === 1'b1) begin
        m_x0 = int'(bus.drw_x0);
        m_n  = int'(bus.drw_x1) - int'(bus.drw_x0) + 1;
        m_y  = int'(bus.drw_y0);
        for (int i = 0; i < m_n; i++) begin
          @(posedge clk); #1;
          if (!reset_n) break;
          bus.drw_pvalid = 1'b1;
          bus.drw_x      = W'(m_x0 + i);
          bus.drw_y      = W'(m_y);
          bus.drw_done   = !hang && (i == m_n - 1);
        end
        @(posedge clk); #1;
        bus.drw_pvalid = 1'b0;
        bus.drw_done   = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // which: 0 = A, 1 = B, 2 = either
  task automatic wait_ack(input int which, output int cyc);
    logic hit;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      hit = (which == 0) ? bus.a_ack : (which == 1) ? bus.b_ack : (bus.a_ack | bus.b_ack);
    end while (hit !== 1'b1 && cyc < 200);
    check("ack_seen", {31'd0, hit}, 32'd1);
  endtask

  task automatic wait_start(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.drw_start !== 1'b1 && cyc < 50);
    check("start_seen", {31'd0, bus.drw_start}, 32'd1);
  endtask

  task automatic set_a(input int x0, input int y0, input int x1, input int y1, input int c);
    bus.a_x0 = W'(x0); bus.a_y0 = W'(y0); bus.a_x1 = W'(x1); bus.a_y1 = W'(y1); bus.a_color = CW'(c);
  endtask

  task automatic set_b(input int x0, input int y0, input int x1, input int y1, input int c);
    bus.b_x0 = W'(x0); bus.b_y0 = W'(y0); bus.b_x1 = W'(x1); bus.b_y1 = W'(y1); bus.b_color = CW'(c);
  endtask

  task automatic clear_logs();
    px.delete(); py.delete(); pc.delete(); ack_q.delete();
    a_acks = 0; b_acks = 0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    clear_logs();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  int cyc;

  initial begin
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",   {31'd0, busy}, 0);
    check("rst_pix_we", {31'd0, bus.pix_we}, 0);
    check("rst_start",  {31'd0, bus.drw_start}, 0);
    check("rst_acks",   {30'd0, bus.a_ack, bus.b_ack}, 0);
    check("rst_err",    {31'd0, err_timeout}, 0);
    check("rst_count",  {16'd0, line_count}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    clear_logs();

    // Single A line (0,0)->(3,0), colour 1
    set_a(0, 0, 3, 0, 1);
    bus.a_req = 1'b1;
    @(negedge clk);
    check("t1_start", {31'd0, bus.drw_start}, 1);
    check("t1_busy",  {31'd0, busy}, 1);
    check("t1_drw_x1", 32'(bus.drw_x1), 3);
    wait_ack(0, cyc);
    bus.a_req = 1'b0;
    check("t1_ack_lat", cyc, 5);
    #1;
    check("t1_npix", px.size(), 4);
    for (int i = 0; i < 4 && i < px.size(); i++) begin
      check("t1_px", px[i], i);
      check("t1_py", py[i], 0);
      check("t1_pc", pc[i], 1);
    end
    check("t1_count", {16'd0, line_count}, 1);
    @(negedge clk);
    check("t1_idle_busy", {31'd0, busy}, 0);
    check("t1_ack_once", a_acks, 1);

    // Simultaneous A and B right after reset: A first, then B with 2-cycle gap
    apply_reset();
    set_a(0, 1, 1, 1, 1);
    set_b(5, 2, 7, 2, 0);
    bus.a_req = 1'b1;
    bus.b_req = 1'b1;
    wait_start(cyc);
    check("t2_first_is_a", 32'(bus.drw_y0), 1);
    wait_ack(0, cyc);
    bus.a_req = 1'b0;
    wait_start(cyc);
    check("t2_gap", cyc, 2);
    check("t2_b_x0", 32'(bus.drw_x0), 5);
    wait_ack(1, cyc);
    bus.b_req = 1'b0;
    #1;
    check("t2_nacks", ack_q.size(), 2);
    if (ack_q.size() == 2) begin
      check("t2_order0", ack_q[0], 0);
      check("t2_order1", ack_q[1], 1);
    end
    check("t2_npix", px.size(), 5);
    if (px.size() == 5) begin
      check("t2_pc0", pc[0], 1);
      check("t2_px2", px[2], 5);
      check("t2_pc2", pc[2], 0);
    end
    check("t2_count", {16'd0, line_count}, 2);

    // Both held for four lines: A,B,A,B
    clear_logs();
    bus.a_req = 1'b1;
    bus.b_req = 1'b1;
    for (int k = 0; k < 4; k++) wait_ack(2, cyc);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    #1;
    check("t3_nacks", ack_q.size(), 4);
    for (int k = 0; k < 4 && k < ack_q.size(); k++) check("t3_order", ack_q[k], k % 2);
    check("t3_a_acks", a_acks, 2);
    check("t3_b_acks", b_acks, 2);
    check("t3_npix", px.size(), 10);
    check("t3_count", {16'd0, line_count}, 6);
    repeat (2) @(negedge clk);
    check("t3_idle", {31'd0, busy}, 0);

    // Watchdog abort: drawer never signals done
    clear_logs();
    hang = 1'b1;
    set_a(0, 5, 2, 5, 1);
    bus.a_req = 1'b1;
    wait_start(cyc);
    wait_ack(0, cyc);
    bus.a_req = 1'b0;
    hang = 1'b0;
    check("t4_abort_lat", cyc, 17);
    check("t4_err", {31'd0, err_timeout}, 1);
    check("t4_count", {16'd0, line_count}, 6);
    #1;
    check("t4_npix", px.size(), 3);
    set_b(5, 2, 7, 2, 0);
    bus.b_req = 1'b1;
    wait_ack(1, cyc);
    bus.b_req = 1'b0;
    check("t4_next_count", {16'd0, line_count}, 7);
    check("t4_err_sticky", {31'd0, err_timeout}, 1);

    // Reset in the middle of a 20-pixel line
    repeat (2) @(negedge clk);
    clear_logs();
    set_a(0, 3, 19, 3, 1);
    bus.a_req = 1'b1;
    wait_start(cyc);
    repeat (6) @(negedge clk);
    check("t5_pix_we_pre", {31'd0, bus.pix_we}, 1);
    #2;
    reset_n = 1'b0;
    bus.a_req = 1'b0;
    #1;
    check("t5_pix_we", {31'd0, bus.pix_we}, 0);
    check("t5_busy",   {31'd0, busy}, 0);
    check("t5_ack",    {31'd0, bus.a_ack}, 0);
    check("t5_drw_x1", 32'(bus.drw_x1), 0);
    check("t5_count",  {16'd0, line_count}, 0);
    check("t5_err",    {31'd0, err_timeout}, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    clear_logs();
    set_b(5, 2, 7, 2, 0);
    bus.b_req = 1'b1;
    wait_start(cyc);
    check("t5_launch_lat", cyc, 1);
    wait_ack(1, cyc);
    bus.b_req = 1'b0;
    check("t5_ack_lat", cyc, 4);
    #1;
    check("t5_npix", px.size(), 3);
    if (px.size() > 0) check("t5_px0", px[0], 5);
    check("t5_new_count", {16'd0, line_count}, 1);
    check("t5_no_a_ack", a_acks, 0);

    // Endpoint changes on A during DRAW do not disturb the active line
    @(negedge clk);
    clear_logs();
    set_a(2, 4, 6, 4, 1);
    bus.a_req = 1'b1;
    wait_start(cyc);
    @(negedge clk);
    set_a(9, 9, 10, 9, 0);
    @(negedge clk);
    check("t6_x0", 32'(bus.drw_x0), 2);
    check("t6_y0", 32'(bus.drw_y0), 4);
    check("t6_x1", 32'(bus.drw_x1), 6);
    check("t6_y1", 32'(bus.drw_y1), 4);
    wait_ack(0, cyc);
    bus.a_req = 1'b0;
    check("t6_x1_ack", 32'(bus.drw_x1), 6);
    #1;
    check("t6_npix", px.size(), 5);
    if (px.size() == 5) begin
      check("t6_px4", px[4], 6);
      check("t6_pc4", pc[4], 1);
    end

    // Zero-length line on B
    @(negedge clk);
    clear_logs();
    set_b(9, 9, 9, 9, 1);
    bus.b_req = 1'b1;
    wait_start(cyc);
    wait_ack(1, cyc);
    bus.b_req = 1'b0;
    check("t7_ack_lat", cyc, 2);
    #1;
    check("t7_npix", px.size(), 1);
    if (px.size() > 0) check("t7_py0", py[0], 9);
    check("t7_count", {16'd0, line_count}, 3);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
